// File: rtl/pld_interleaver.sv
// Ping-pong block interleaver for punctured coded bits. Each symbol of N_CBPS
// bits (set by mod_sel) is written in permuted order into one N_MAX-bit bank
// while the other bank is read out sequentially.
// The interleaved output port is named do_bit because 'do' is a reserved word.
module pld_interleaver #(
    parameter int unsigned N_MAX = 288,
    parameter int unsigned SYM_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             done_rst,
    input  logic [1:0]       mod_sel,
    input  logic             di,
    input  logic             di_vld,
    output logic             di_rdy,
    output logic             do_bit,
    output logic             do_vld,
    output logic [SYM_W-1:0] do_sym_num,
    output logic             ovf
);
    localparam int unsigned AW = $clog2(N_MAX + 1);

    typedef enum logic {RD_IDLE, RD_BUSY} rd_state_t;

    // Bits per symbol for each modulation.
    function automatic logic [AW-1:0] n_cbps(input logic [1:0] m);
        case (m)
            2'd0:    n_cbps = AW'(48);
            2'd1:    n_cbps = AW'(96);
            2'd2:    n_cbps = AW'(192);
            default: n_cbps = AW'(288);
        endcase
    endfunction

    // Bits per subcarrier axis, s = max(N_BPSC/2, 1).
    function automatic logic [1:0] s_of(input logic [1:0] m);
        case (m)
            2'd0, 2'd1: s_of = 2'd1;
            2'd2:       s_of = 2'd2;
            default:    s_of = 2'd3;
        endcase
    endfunction

    // Column stride N_CBPS/16 of the first permutation.
    function automatic logic [AW-1:0] step_of(input logic [1:0] m);
        case (m)
            2'd0:    step_of = AW'(3);
            2'd1:    step_of = AW'(6);
            2'd2:    step_of = AW'(12);
            default: step_of = AW'(18);
        endcase
    endfunction

    // Increment modulo s (s <= 3).
    function automatic logic [1:0] inc_mod(input logic [1:0] x, input logic [1:0] s);
        inc_mod = (2'(x + 2'd1) == s) ? 2'd0 : 2'(x + 2'd1);
    endfunction

    // Write-side counters: k = 16*row + col, colbase = (N_CBPS/16)*col.
    logic [AW-1:0]    k_q, row_q, colbase_q;
    logic [3:0]       col_q;
    logic [1:0]       row_m_q, col_m_q;
    logic [1:0]       wr_mod_q, rd_mod_q;
    logic             wr_sel_q, wr_full_q;
    logic [AW-1:0]    rd_addr_q;
    logic [SYM_W-1:0] sym_cnt_q;
    logic [N_MAX-1:0] bank_q [2];
    rd_state_t        rd_state_q, rd_state_nxt;

    logic [1:0]    cur_mod, cur_s, off;
    logic [AW-1:0] cur_n, cur_step, rd_n, i_addr, j_addr;
    logic          accept, wr_last, swap, rd_last, wr_full_nxt;

    // Write address generation without dividers. Since N_CBPS/16 and N_CBPS
    // are multiples of s, i mod s = row mod s and floor(16i/N_CBPS) = col, so
    // j = i - (row mod s) + ((row - col) mod s).
    always_comb begin
        cur_mod     = (k_q == '0) ? mod_sel : wr_mod_q;
        cur_n       = n_cbps(cur_mod);
        cur_s       = s_of(cur_mod);
        cur_step    = step_of(cur_mod);
        rd_n        = n_cbps(rd_mod_q);
        accept      = di_vld & di_rdy;
        wr_last     = (k_q == AW'(cur_n - AW'(1)));
        swap        = wr_full_q && (rd_state_q == RD_IDLE);
        i_addr      = AW'(colbase_q + row_q);
        off         = (row_m_q >= col_m_q) ? 2'(row_m_q - col_m_q)
                                           : 2'(row_m_q + cur_s - col_m_q);
        j_addr      = AW'(i_addr - AW'(row_m_q) + AW'(off));
        wr_full_nxt = wr_full_q;
        if (accept && wr_last) begin
            wr_full_nxt = 1'b1;
        end else if (swap) begin
            wr_full_nxt = 1'b0;
        end
    end

    // Read controller next state: idle until a full bank is handed over.
    always_comb begin
        rd_state_nxt = rd_state_q;
        rd_last      = (rd_addr_q == AW'(rd_n - AW'(1)));
        if (done_rst) begin
            rd_state_nxt = RD_IDLE;
        end else begin
            case (rd_state_q)
                RD_IDLE: if (swap)    rd_state_nxt = RD_BUSY;
                RD_BUSY: if (rd_last) rd_state_nxt = RD_IDLE;
                default:              rd_state_nxt = RD_IDLE;
            endcase
        end
    end

    // Write-side counters, bank handover, ready and overflow flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_q       <= '0;
            row_q     <= '0;
            colbase_q <= '0;
            col_q     <= '0;
            row_m_q   <= '0;
            col_m_q   <= '0;
            wr_mod_q  <= '0;
            rd_mod_q  <= '0;
            wr_sel_q  <= 1'b0;
            wr_full_q <= 1'b0;
            di_rdy    <= 1'b0;
            ovf       <= 1'b0;
        end else if (done_rst) begin
            k_q       <= '0;
            row_q     <= '0;
            colbase_q <= '0;
            col_q     <= '0;
            row_m_q   <= '0;
            col_m_q   <= '0;
            wr_full_q <= 1'b0;
            di_rdy    <= 1'b1;
            ovf       <= 1'b0;
        end else begin
            if (di_vld && !di_rdy) begin
                ovf <= 1'b1;
            end
            if (accept) begin
                if (k_q == '0) begin
                    wr_mod_q <= mod_sel;
                end
                if (wr_last) begin
                    k_q       <= '0;
                    row_q     <= '0;
                    colbase_q <= '0;
                    col_q     <= '0;
                    row_m_q   <= '0;
                    col_m_q   <= '0;
                end else begin
                    k_q <= AW'(k_q + AW'(1));
                    if (col_q == 4'd15) begin
                        col_q     <= '0;
                        colbase_q <= '0;
                        col_m_q   <= '0;
                        row_q     <= AW'(row_q + AW'(1));
                        row_m_q   <= inc_mod(row_m_q, cur_s);
                    end else begin
                        col_q     <= 4'(col_q + 4'd1);
                        colbase_q <= AW'(colbase_q + cur_step);
                        col_m_q   <= inc_mod(col_m_q, cur_s);
                    end
                end
            end
            if (swap) begin
                wr_sel_q <= ~wr_sel_q;
                rd_mod_q <= wr_mod_q;
            end
            wr_full_q <= wr_full_nxt;
            di_rdy    <= ~wr_full_nxt;
        end
    end

    // Bank storage; occupancy is tracked by the flags, so no reset is needed.
    always_ff @(posedge clk) begin
        if (accept && !done_rst) begin
            bank_q[wr_sel_q][j_addr] <= di;
        end
    end

    // Sequential read-out of the read bank with symbol numbering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state_q <= RD_IDLE;
            rd_addr_q  <= '0;
            sym_cnt_q  <= '0;
            do_bit     <= 1'b0;
            do_vld     <= 1'b0;
            do_sym_num <= '0;
        end else begin
            rd_state_q <= rd_state_nxt;
            if (done_rst) begin
                rd_addr_q  <= '0;
                sym_cnt_q  <= '0;
                do_bit     <= 1'b0;
                do_vld     <= 1'b0;
                do_sym_num <= '0;
            end else if (rd_state_q == RD_BUSY) begin
                do_bit     <= bank_q[~wr_sel_q][rd_addr_q];
                do_vld     <= 1'b1;
                do_sym_num <= sym_cnt_q;
                if (rd_last) begin
                    rd_addr_q <= '0;
                    sym_cnt_q <= SYM_W'(sym_cnt_q + SYM_W'(1));
                end else begin
                    rd_addr_q <= AW'(rd_addr_q + AW'(1));
                end
            end else begin
                do_bit <= 1'b0;
                do_vld <= 1'b0;
            end
        end
    end

endmodule
